lsu_mem_master: RTL and testbench

- Data-side initiator for the integrated instruction/data memory's data port. It drives data_addr, data_in, mem_read and mem_write, and samples data_out.
- Accepts one load/store request at a time from the CPU datapath (valid/ready). Word, halfword and byte sizes with optional sign extension; sub-word stores use read-modify-write.
- Generates a clean, glitch-free single-cycle mem_write pulse with address and data stable on both sides, because the memory writes on the rising edge of mem_write.

---
 rtl/lsu_mem_master_if.sv | 36 +++
 rtl/lsu_mem_master.sv | 146 ++++++++++++++
 tb/tb_lsu_mem_master.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/lsu_mem_master_if.sv
// Purpose: load/store request/response channel plus data-port memory bus of lsu_mem_master.
// Latency: wires only; no logic.
// Backpressure: req_valid/req_ready on requests; responses and memory strobes are not backpressured.
// Ports: req_* (CPU -> LSU), req_ready/resp_* (LSU -> CPU),
//        data_addr/data_in/mem_read/mem_write (LSU -> memory), data_out (memory -> LSU).
interface lsu_mem_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_signed;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_addr;
    logic [31:0] data_in;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] data_out;

    // master: the LSU itself (accepts requests, initiates memory accesses)
    modport master (
        input  req_valid, req_write, req_size, req_signed, req_addr, req_wdata, data_out,
        output req_ready, resp_valid, resp_rdata, resp_err,
        output data_addr, data_in, mem_read, mem_write
    );

    // slave: the environment (CPU request side and the memory)
    modport slave (
        output req_valid, req_write, req_size, req_signed, req_addr, req_wdata, data_out,
        input  req_ready, resp_valid, resp_rdata, resp_err,
        input  data_addr, data_in, mem_read, mem_write
    );
endinterface

// File: rtl/lsu_mem_master.sv
// Purpose: data-port initiator; byte/half/word loads and stores, sub-word stores via read-modify-write.
// Latency: resp_valid 2 cycles after accept for loads, 4 word store, 5 sub-word store, 1 on error.
// Backpressure: one request in flight; req_ready only in IDLE; no response backpressure.
// Ports: clk, rst_n (async active-low), bus (lsu_mem_master_if.master).
module lsu_mem_master #(
    parameter logic [31:0] DATA_LIMIT = 32'h0000_1000
) (
    input  logic              clk,
    input  logic              rst_n,
    lsu_mem_master_if.master  bus
);
    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_RD      = 3'd1;
    localparam logic [2:0] S_WSETUP  = 3'd2;
    localparam logic [2:0] S_WSTROBE = 3'd3;
    localparam logic [2:0] S_WHOLD   = 3'd4;
    localparam logic [2:0] S_RESP    = 3'd5;

    logic [2:0]  state_q, state_d;
    logic        write_q, signed_q;
    logic [1:0]  size_q, lane_q;
    logic [31:0] wdata_q;
    logic [31:0] data_addr_q, data_addr_d;
    logic [31:0] data_in_q, data_in_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        mem_read_q, mem_write_q, resp_valid_q;

    logic        accept, req_bad;
    logic [7:0]  byte_v;
    logic [15:0] half_v;
    logic [31:0] load_val, merge_val;

    assign bus.req_ready  = rst_n && (state_q == S_IDLE);
    assign accept         = bus.req_valid && bus.req_ready;

    assign bus.data_addr  = data_addr_q;
    assign bus.data_in    = data_in_q;
    assign bus.mem_read   = mem_read_q;
    assign bus.mem_write  = mem_write_q;
    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_rdata = rdata_q;
    assign bus.resp_err   = err_q;

    always_comb begin
        req_bad = (bus.req_size == 2'b11)
               || (bus.req_size == 2'b01 && bus.req_addr[0])
               || (bus.req_size == 2'b10 && bus.req_addr[1:0] != 2'b00)
               || (bus.req_addr >= DATA_LIMIT);
    end

    // Lane extraction for loads and lane replacement for sub-word stores.
    always_comb begin
        byte_v    = bus.data_out[{lane_q, 3'b000} +: 8];
        half_v    = bus.data_out[{lane_q[1], 4'b0000} +: 16];
        load_val  = bus.data_out;
        merge_val = bus.data_out;
        case (size_q)
            2'b00:   load_val = {{24{signed_q & byte_v[7]}}, byte_v};
            2'b01:   load_val = {{16{signed_q & half_v[15]}}, half_v};
            default: load_val = bus.data_out;
        endcase
        if (size_q == 2'b00) begin
            merge_val[{lane_q, 3'b000} +: 8] = wdata_q[7:0];
        end else begin
            merge_val[{lane_q[1], 4'b0000} +: 16] = wdata_q[15:0];
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    if (req_bad)
                        state_d = S_RESP;
                    else if (bus.req_write && bus.req_size == 2'b10)
                        state_d = S_WSETUP;
                    else
                        state_d = S_RD;
                end
            end
            S_RD:      state_d = write_q ? S_WSETUP : S_RESP;
            S_WSETUP:  state_d = S_WSTROBE;
            S_WSTROBE: state_d = S_WHOLD;
            S_WHOLD:   state_d = S_RESP;
            S_RESP:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase
    end

    // Address/data change only on accept or at the end of RD, so they are
    // stable for the whole WSETUP..WHOLD window around the write strobe.
    always_comb begin
        data_addr_d = data_addr_q;
        data_in_d   = data_in_q;
        rdata_d     = rdata_q;
        err_d       = err_q;
        if (accept && !req_bad) begin
            data_addr_d = {bus.req_addr[31:2], 2'b00};
            if (bus.req_write && bus.req_size == 2'b10)
                data_in_d = bus.req_wdata;
        end
        if (state_q == S_RD && write_q)
            data_in_d = merge_val;
        // Response fields only update on entry to RESP, then hold.
        if (state_d == S_RESP && state_q != S_RESP) begin
            err_d   = (state_q == S_IDLE);
            rdata_d = (state_q == S_RD && !write_q) ? load_val : 32'h0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            write_q      <= 1'b0;
            signed_q     <= 1'b0;
            size_q       <= 2'b00;
            lane_q       <= 2'b00;
            wdata_q      <= 32'h0;
            data_addr_q  <= 32'h0;
            data_in_q    <= 32'h0;
            rdata_q      <= 32'h0;
            err_q        <= 1'b0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            resp_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            if (accept) begin
                write_q  <= bus.req_write;
                signed_q <= bus.req_signed;
                size_q   <= bus.req_size;
                lane_q   <= bus.req_addr[1:0];
                wdata_q  <= bus.req_wdata;
            end
            data_addr_q  <= data_addr_d;
            data_in_q    <= data_in_d;
            rdata_q      <= rdata_d;
            err_q        <= err_d;
            mem_read_q   <= (state_d == S_RD);
            mem_write_q  <= (state_d == S_WSTROBE);
            resp_valid_q <= (state_d == S_RESP);
        end
    end
endmodule

// File: tb/tb_lsu_mem_master.sv
// Purpose: directed self-checking bench for lsu_mem_master with a small word memory model.
// Latency: cycle n = interval following the n-th rising edge after the accept edge.
// Backpressure: requests issued one at a time except the held-valid back-to-back case.
module tb_lsu_mem_master;
    logic clk;
    logic rst_n;
    int   tests;
    int   fails;
    int   wr_pulses;
    logic [31:0] mem [0:63];

    lsu_mem_master_if bus ();

    lsu_mem_master #(.DATA_LIMIT(32'h0000_1000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory: combinational read, write commits on the rising edge of mem_write.
    assign bus.data_out = mem[bus.data_addr[7:2]];
    always @(posedge bus.mem_write) begin
        wr_pulses = wr_pulses + 1;
        mem[bus.data_addr[7:2]] = bus.data_in;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Issues one request from a post-edge point and watches cycles 1..8.
    // rd_cyc: cycle where mem_read must be high (0 = never).
    // ws: WSETUP cycle (0 = no write); strobe expected in ws+1.
    task automatic run_req(input string tag, input logic w, input logic [1:0] sz, input logic sg,
                           input logic [31:0] a, input logic [31:0] wd,
                           input int exp_resp, input logic [31:0] exp_rd, input logic exp_err,
                           input int rd_cyc, input int ws, input logic [31:0] exp_din);
        int resp_cyc;
        int nresp;
        logic [31:0] got_rd;
        logic got_err;
        resp_cyc = 0;
        nresp    = 0;
        got_rd   = 32'hx;
        got_err  = 1'bx;
        chk({tag, "_ready"}, {31'd0, bus.req_ready}, 32'd1);
        bus.req_valid  = 1'b1;
        bus.req_write  = w;
        bus.req_size   = sz;
        bus.req_signed = sg;
        bus.req_addr   = a;
        bus.req_wdata  = wd;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            if (bus.resp_valid) begin
                nresp++;
                resp_cyc = c;
                got_rd   = bus.resp_rdata;
                got_err  = bus.resp_err;
            end
            chk($sformatf("%s_mem_read_c%0d", tag, c), {31'd0, bus.mem_read}, {31'd0, c == rd_cyc});
            if (bus.mem_read)
                chk({tag, "_rd_addr"}, bus.data_addr, {a[31:2], 2'b00});
            if (ws != 0 && c >= ws && c <= ws + 2) begin
                chk($sformatf("%s_waddr_c%0d", tag, c), bus.data_addr, {a[31:2], 2'b00});
                chk($sformatf("%s_wdata_c%0d", tag, c), bus.data_in, exp_din);
                chk($sformatf("%s_mem_write_c%0d", tag, c), {31'd0, bus.mem_write}, {31'd0, c == ws + 1});
            end else begin
                chk($sformatf("%s_mem_write_c%0d", tag, c), {31'd0, bus.mem_write}, 32'd0);
            end
            @(posedge clk); #1;
        end
        chk({tag, "_resp_cycle"}, resp_cyc, exp_resp);
        chk({tag, "_resp_count"}, nresp, 32'd1);
        chk({tag, "_rdata"}, got_rd, exp_rd);
        chk({tag, "_err"}, {31'd0, got_err}, {31'd0, exp_err});
    endtask

    initial begin
        int pulses0;
        int r1, r2;
        logic [31:0] d1, d2;
        tests = 0;
        fails = 0;
        wr_pulses = 0;
        for (int i = 0; i < 64; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        mem[5] = 32'h11223344;
        mem[8] = 32'h01020304;
        mem[9] = 32'h55667788;
        bus.req_valid  = 1'b0;
        bus.req_write  = 1'b0;
        bus.req_size   = 2'b00;
        bus.req_signed = 1'b0;
        bus.req_addr   = 32'h0;
        bus.req_wdata  = 32'h0;
        rst_n = 1'b0;
        #1;
        chk("rst_ready",      {31'd0, bus.req_ready},  32'd0);
        chk("rst_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("rst_resp_err",   {31'd0, bus.resp_err},   32'd0);
        chk("rst_rdata",      bus.resp_rdata,          32'd0);
        chk("rst_mem_read",   {31'd0, bus.mem_read},   32'd0);
        chk("rst_mem_write",  {31'd0, bus.mem_write},  32'd0);
        chk("rst_data_addr",  bus.data_addr,           32'd0);
        chk("rst_data_in",    bus.data_in,             32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Loads
        run_req("lw10",  1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 2, 32'h8899AABB, 1'b0, 1, 0, 32'h0);
        run_req("lb11",  1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 2, 32'hFFFFFFAA, 1'b0, 1, 0, 32'h0);
        run_req("lbu13", 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 2, 32'h00000088, 1'b0, 1, 0, 32'h0);
        run_req("lh12",  1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 2, 32'hFFFF8899, 1'b0, 1, 0, 32'h0);
        run_req("lhu10", 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 2, 32'h0000AABB, 1'b0, 1, 0, 32'h0);

        // Stores
        pulses0 = wr_pulses;
        run_req("sb12", 1'b1, 2'b00, 1'b0, 32'h12, 32'h12345678, 5, 32'h0, 1'b0, 1, 2, 32'h8878AABB);
        chk("sb12_mem",    mem[4], 32'h8878AABB);
        chk("sb12_pulses", wr_pulses - pulses0, 32'd1);
        run_req("sw24", 1'b1, 2'b10, 1'b0, 32'h24, 32'hCAFEF00D, 4, 32'h0, 1'b0, 0, 1, 32'hCAFEF00D);
        chk("sw24_mem", mem[9], 32'hCAFEF00D);
        run_req("sh26", 1'b1, 2'b01, 1'b0, 32'h26, 32'hFFFF1234, 5, 32'h0, 1'b0, 1, 2, 32'h1234F00D);
        chk("sh26_mem", mem[9], 32'h1234F00D);

        // Errors: no memory activity, err in cycle 1
        pulses0 = wr_pulses;
        run_req("err_lw12",  1'b0, 2'b10, 1'b0, 32'h12,   32'h0,        1, 32'h0, 1'b1, 0, 0, 32'h0);
        run_req("err_sw1000",1'b1, 2'b10, 1'b0, 32'h1000, 32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, 0, 32'h0);
        run_req("err_size3", 1'b1, 2'b11, 1'b0, 32'h10,   32'hFFFFFFFF, 1, 32'h0, 1'b1, 0, 0, 32'h0);
        chk("err_mem_unchanged", mem[4], 32'h8878AABB);
        chk("err_no_pulses", wr_pulses - pulses0, 32'd0);
        // A good load after errors clears resp_err
        run_req("lw14", 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 2, 32'h11223344, 1'b0, 1, 0, 32'h0);

        // Reset during WSETUP aborts the store
        pulses0 = wr_pulses;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hDEADBEEF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("abort_ready",      {31'd0, bus.req_ready},  32'd0);
        chk("abort_resp_valid", {31'd0, bus.resp_valid}, 32'd0);
        chk("abort_resp_err",   {31'd0, bus.resp_err},   32'd0);
        chk("abort_rdata",      bus.resp_rdata,          32'd0);
        chk("abort_mem_read",   {31'd0, bus.mem_read},   32'd0);
        chk("abort_mem_write",  {31'd0, bus.mem_write},  32'd0);
        chk("abort_data_addr",  bus.data_addr,           32'd0);
        chk("abort_data_in",    bus.data_in,             32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("abort_ready_after", {31'd0, bus.req_ready}, 32'd1);
        for (int c = 0; c < 6; c++) begin
            chk($sformatf("abort_no_resp_%0d", c), {31'd0, bus.resp_valid}, 32'd0);
            chk($sformatf("abort_no_wr_%0d", c),   {31'd0, bus.mem_write},  32'd0);
            @(posedge clk); #1;
        end
        chk("abort_mem_unchanged", mem[8], 32'h01020304);
        chk("abort_no_pulses", wr_pulses - pulses0, 32'd0);

        // Back-to-back loads with req_valid held high
        r1 = 0; r2 = 0; d1 = 32'h0; d2 = 32'h0;
        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_size  = 2'b10;
        bus.req_addr  = 32'h10;
        @(posedge clk); #1;
        bus.req_addr  = 32'h14;
        for (int c = 1; c <= 8; c++) begin
            if (c <= 4)
                chk($sformatf("b2b_ready_c%0d", c), {31'd0, bus.req_ready}, {31'd0, c == 3});
            if (c == 4)
                bus.req_valid = 1'b0;
            if (bus.resp_valid) begin
                if (r1 == 0) begin
                    r1 = c; d1 = bus.resp_rdata;
                end else begin
                    r2 = c; d2 = bus.resp_rdata;
                end
            end
            @(posedge clk); #1;
        end
        chk("b2b_resp1_cycle", r1, 32'd2);
        chk("b2b_resp2_cycle", r2, 32'd5);
        chk("b2b_resp1_data",  d1, 32'h8878AABB);
        chk("b2b_resp2_data",  d2, 32'h11223344);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
